// File: rtl/rf32_stream_reader_pkg.sv
// Shared definitions for the 16x32 register-file stream reader.
package rf32_stream_reader_pkg;
  localparam int RF_DW    = 32;
  localparam int RF_AW    = 4;
  localparam int RF_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/rf32_stream_reader.sv
// Streams a wrapping address range of the register file out on valid/ready.
// Optional even-parity sideband output: define RF32_STREAM_READER_PARITY_EN.
module rf32_stream_reader
  import rf32_stream_reader_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_dout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
`ifdef RF32_STREAM_READER_PARITY_EN
  output logic          m_parity,
`endif
  output logic          busy,
  output logic          done
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  state_e        r_state, w_next;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_data;
  logic          r_valid, r_last, r_par;
  logic          w_load, w_finish, w_hs;
  logic [AW:0]   w_len_clip;

  assign w_hs       = r_valid & m_ready;
  assign w_len_clip = (len > DEPTH) ? DEPTH : len;

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = (len == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: begin
        w_load = 1'b1;
        w_next = ST_SEND;
      end
      ST_SEND: begin
        if (w_hs) begin
          if (r_last) begin
            w_finish = 1'b1;
            w_next   = ST_DONE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Word is captured from rf_dout on the edge it enters m_data (snapshot).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start) begin
        r_ptr <= base_addr;
        r_cnt <= w_len_clip;
      end
      if (w_load) begin
        r_data  <= rf_dout;
        r_par   <= ^rf_dout;
        r_valid <= 1'b1;
        r_last  <= (r_cnt == ONE);
        r_ptr   <= r_ptr + 1'b1;
        r_cnt   <= r_cnt - ONE;
      end
      if (w_finish) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign rf_ra   = (r_state == ST_LOAD || r_state == ST_SEND) ? r_ptr : '0;
  assign m_data  = r_data;
  assign m_valid = r_valid;
  assign m_last  = r_last;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);

`ifdef RF32_STREAM_READER_PARITY_EN
  assign m_parity = r_par;
`else
  logic w_unused_par;
  assign w_unused_par = r_par;
`endif
endmodule

// File: tb/tb_rf32_stream_reader.sv
// Directed bench for rf32_stream_reader with a queue-based reference model.
module tb_rf32_stream_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  len = '0;
  logic [3:0]  rf_ra;
  logic [31:0] rf_dout;
  logic [31:0] m_data;
  logic        m_valid, m_last, busy, done;
  logic        m_ready;
`ifdef RF32_STREAM_READER_PARITY_EN
  logic        m_parity;
`endif

  logic [31:0] rf [16];
  assign rf_dout = rf[rf_ra];

  rf32_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .rf_ra(rf_ra), .rf_dout(rf_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last),
`ifdef RF32_STREAM_READER_PARITY_EN
    .m_parity(m_parity),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Backpressure: ready follows 1,0,0 repeating while bp_en is set.
  bit bp_en = 1'b0;
  int bp_i = 0;
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      m_ready = (bp_i % 3 == 0);
      bp_i++;
    end else begin
      m_ready = 1'b1;
      bp_i = 0;
    end
  end
  initial m_ready = 1'b1;

  // Reference model: the command becomes a queue of addresses; words are
  // popped one per accepted beat, the stream ends with one done cycle.
  logic [3:0]  q[$];
  bit          e_busy, e_valid, e_last, e_done, arm;
  logic [31:0] e_data;
  always @(posedge clk or posedge rst) begin
    int n;
    logic [3:0] a;
    if (rst) begin
      q.delete();
      e_busy = 0; e_valid = 0; e_last = 0; e_done = 0; arm = 0; e_data = '0;
    end else if (e_done) begin
      e_done = 0; e_busy = 0;
    end else if (!e_busy) begin
      if (start) begin
        n = (len > 16) ? 16 : int'(len);
        for (int i = 0; i < n; i++) q.push_back(4'(int'(base_addr) + i));
        e_busy = 1;
        if (n == 0) e_done = 1; else arm = 1;
      end
    end else if (arm || (e_valid && m_ready && !e_last)) begin
      a = q.pop_front();
      e_data = rf[a]; e_valid = 1; e_last = (q.size() == 0); arm = 0;
    end else if (e_valid && m_ready) begin
      e_valid = 0; e_last = 0; e_done = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_valid", {31'b0, m_valid}, {31'b0, e_valid});
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("done", {31'b0, done}, {31'b0, e_done});
      if (e_valid) begin
        chk("m_data", m_data, e_data);
        chk("m_last", {31'b0, m_last}, {31'b0, e_last});
`ifdef RF32_STREAM_READER_PARITY_EN
        chk("m_parity", {31'b0, m_parity}, {31'b0, ^e_data});
`endif
      end
      if (!e_busy) chk("rf_ra_idle", {28'b0, rf_ra}, 32'h0);
    end
  end

  // Handshake / done log for the literal checks.
  int cyc = 0;
  logic [31:0] got[$];
  bit gl[$];
  int hc[$];
  int dc[$];
`ifdef RF32_STREAM_READER_PARITY_EN
  bit gp[$];
`endif
  always @(posedge clk) begin
    cyc++;
    if (!rst && m_valid && m_ready) begin
      got.push_back(m_data); gl.push_back(m_last); hc.push_back(cyc);
`ifdef RF32_STREAM_READER_PARITY_EN
      gp.push_back(m_parity);
`endif
    end
    if (!rst && done) dc.push_back(cyc);
  end

  int sc;
  task automatic run(input logic [3:0] b, input logic [4:0] l, input bit bump);
    bit ok;
    got.delete(); gl.delete(); hc.delete(); dc.delete();
`ifdef RF32_STREAM_READER_PARITY_EN
    gp.delete();
`endif
    @(posedge clk); #2;
    start = 1; base_addr = b; len = l; sc = cyc + 1;
    @(posedge clk); #2;
    start = 0;
    ok = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #2;
      if (bump && k == 2) begin start = 1; base_addr = 4'hC; len = 5'd2; end
      if (bump && k == 3) start = 0;
      if (dc.size() > 0) begin ok = 1; break; end
    end
    chk("done_timeout", {31'b0, ok}, 32'h1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 16; i++) rf[i] = 32'hA000_0000 + i;
    #2;
    chk("rst_valid", {31'b0, m_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_ra", {28'b0, rf_ra}, 32'h0);
    #10 rst = 0;

    // base 3, len 4, full throughput
    run(4'd3, 5'd4, 0);
    chk("t2_n", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("t2_word", got[i], 32'hA000_0003 + i);
      chk("t2_last", {31'b0, gl[i]}, {31'b0, i == 3});
      chk("t2_cycle", hc[i], sc + 2 + i);
    end
    chk("t2_done_n", dc.size(), 1);
    if (dc.size() > 0 && hc.size() == 4) chk("t2_done_cyc", dc[0], hc[3] + 1);

    // wrap: base 14, len 4
    run(4'd14, 5'd4, 0);
    chk("t3_n", got.size(), 4);
    if (got.size() == 4) begin
      chk("t3_w0", got[0], 32'hA000_000E);
      chk("t3_w1", got[1], 32'hA000_000F);
      chk("t3_w2", got[2], 32'hA000_0000);
      chk("t3_w3", got[3], 32'hA000_0001);
      chk("t3_last", {31'b0, gl[3]}, 32'h1);
      chk("t3_nolast", {31'b0, gl[2]}, 32'h0);
    end

    // len 0 and len clipping
    run(4'd7, 5'd0, 0);
    chk("t4_len0_beats", got.size(), 0);
    chk("t4_len0_done", dc.size(), 1);
    if (dc.size() > 0) chk("t4_len0_cyc", dc[0], sc + 1);
    run(4'd5, 5'd20, 0);
    chk("t4_clip_n", got.size(), 16);
    if (got.size() == 16) begin
      chk("t4_clip_first", got[0], 32'hA000_0005);
      chk("t4_clip_last", got[15], 32'hA000_0004);
      chk("t4_clip_lastflag", {31'b0, gl[15]}, 32'h1);
    end

    // backpressure plus ignored start while busy
    bp_en = 1;
    run(4'd0, 5'd6, 1);
    bp_en = 0;
    chk("t5_n", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("t5_word", got[i], 32'hA000_0000 + i);
    chk("t5_done_n", dc.size(), 1);

    // async reset on beat 2 of 5
    got.delete(); dc.delete();
    @(posedge clk); #2;
    start = 1; base_addr = 4'd0; len = 5'd5;
    @(posedge clk); #2;
    start = 0;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (got.size() == 1) begin ok = 1; break; end
      @(posedge clk); #2;
    end
    chk("t1_reach_beat2", {31'b0, ok}, 32'h1);
    chk("t1_pre_valid", {31'b0, m_valid}, 32'h1);
    rst = 1;
    #1;
    chk("t1_valid", {31'b0, m_valid}, 32'h0);
    chk("t1_data", m_data, 32'h0);
    chk("t1_last", {31'b0, m_last}, 32'h0);
    chk("t1_busy", {31'b0, busy}, 32'h0);
    chk("t1_done", {31'b0, done}, 32'h0);
    chk("t1_ra", {28'b0, rf_ra}, 32'h0);
    @(posedge clk); #2;
    rst = 0;
    run(4'd8, 5'd2, 0);
    chk("t1_after_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("t1_after_w0", got[0], 32'hA000_0008);
      chk("t1_after_w1", got[1], 32'hA000_0009);
    end

`ifdef RF32_STREAM_READER_PARITY_EN
    rf[0] = 32'h0000_0007;
    rf[1] = 32'h0000_0003;
    run(4'd0, 5'd2, 0);
    chk("t6_n", got.size(), 2);
    if (gp.size() == 2) begin
      chk("t6_par7", {31'b0, gp[0]}, 32'h1);
      chk("t6_par3", {31'b0, gp[1]}, 32'h0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
